monitor_contador_mod: RTL

- Consumes the 3-bit modulo-5 count produced by the upstream counter stage.
- Checks that successive samples step by +1 mod MODULO, acquires and tracks lock, emits a one-cycle wrap pulse, and counts completed periods.
- Flags out-of-range codes and sequence breaks through a sticky error with a first-error code.
- Sits directly downstream of the counter, in the same clock domain.

---
 rtl/monitor_contador_mod.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/monitor_contador_mod.sv
// monitor_contador_mod: watches a modulo-MODULO count stream from the
// upstream counter. It acquires and tracks lock, pulses Volta on each valid
// wrap, counts completed periods, and keeps a sticky first-error code.
module monitor_contador_mod #(
    parameter int MODULO = 5,
    parameter int CNT_W  = 3,
    parameter int LOCK_N = 4,
    parameter int PER_W  = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Habilita,
    input  logic [CNT_W-1:0] Entrada,
    input  logic             LimpaErro,
    output logic             Sincronizado,
    output logic             Volta,
    output logic [PER_W-1:0] Periodos,
    output logic             Erro,
    output logic [1:0]       CodigoErro
);

    localparam int ACW = $clog2(LOCK_N + 1);

    // One extra bit so that MODULO itself is representable in the range compare.
    localparam logic [CNT_W:0]   MOD_V  = (CNT_W + 1)'(MODULO);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MODULO - 1);
    localparam logic [ACW-1:0]   LOCK_LAST = ACW'(LOCK_N - 1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_SEQ   = 2'b10;

    typedef enum logic [1:0] {
        BUSCA = 2'd0,
        TRAVA = 2'd1,
        SINC  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic [ACW-1:0]   acertos_q, acertos_d;
    logic             volta_q, volta_d;
    logic [PER_W-1:0] periodos_q, periodos_d;
    logic             erro_q, erro_d;
    logic [1:0]       codigo_q, codigo_d;

    logic             in_range;
    logic             prev_last;
    logic [CNT_W-1:0] expected;
    logic             match;
    logic             raise_err;
    logic [1:0]       err_code;

    // Sample decode: range check and expected next value after prev.
    always_comb begin
        in_range  = ({1'b0, Entrada} < MOD_V);
        prev_last = (prev_q == LAST_V);
        expected  = prev_last ? '0 : prev_q + CNT_W'(1);
        match     = in_range && (Entrada == expected);
    end

    // State register and all registered outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= BUSCA;
            prev_q     <= '0;
            acertos_q  <= '0;
            volta_q    <= 1'b0;
            periodos_q <= '0;
            erro_q     <= 1'b0;
            codigo_q   <= ERR_NONE;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q    <= state_d;
            prev_q     <= prev_d;
            acertos_q  <= acertos_d;
            volta_q    <= volta_d;
            periodos_q <= periodos_d;
            erro_q     <= erro_d;
            codigo_q   <= codigo_d;
        end
    end

    // Next-state logic: lock acquisition/tracking and error detection.
    always_comb begin
        // NOTE: defaults first so every path assigns every target (no latches).
        state_d   = state_q;
        prev_d    = prev_q;
        acertos_d = acertos_q;
        raise_err = 1'b0;
        err_code  = ERR_NONE;
        if (Habilita) begin
            unique case (state_q)
                BUSCA: begin
                    if (in_range) begin
                        state_d   = TRAVA;
                        prev_d    = Entrada;
                        acertos_d = '0;
                    end else begin
                        raise_err = 1'b1;
                        err_code  = ERR_RANGE;
                    end
                end
                TRAVA: begin
                    if (!in_range) begin
                        state_d   = BUSCA;
                        raise_err = 1'b1;
                        err_code  = ERR_RANGE;
                    end else if (match) begin
                        prev_d = Entrada;
                        if (acertos_q == LOCK_LAST) begin
                            state_d   = SINC;
                            acertos_d = '0;
                        end else begin
                            acertos_d = acertos_q + ACW'(1);
                        end
                    end else begin
                        // Still acquiring: restart the run without flagging.
                        prev_d    = Entrada;
                        acertos_d = '0;
                    end
                end
                SINC: begin
                    if (!in_range) begin
                        state_d   = BUSCA;
                        raise_err = 1'b1;
                        err_code  = ERR_RANGE;
                    end else if (match) begin
                        prev_d = Entrada;
                    end else begin
                        state_d   = TRAVA;
                        prev_d    = Entrada;
                        acertos_d = '0;
                        raise_err = 1'b1;
                        err_code  = ERR_SEQ;
                    end
                end
                default: begin
                    state_d   = BUSCA;
                    acertos_d = '0;
                end
            endcase
        end
    end

    // Output next values: wrap pulse, saturating period count, sticky error.
    always_comb begin
        volta_d    = Habilita && (state_q == SINC) && prev_last && (Entrada == '0);
        periodos_d = periodos_q;
        if (volta_d && (periodos_q != '1)) begin
            periodos_d = periodos_q + PER_W'(1);
        end
        erro_d   = erro_q;
        codigo_d = codigo_q;
        if (raise_err) begin
            // A clear in the same cycle makes this the first error again.
            erro_d = 1'b1;
            if (!erro_q || LimpaErro) begin
                codigo_d = err_code;
            end
        end else if (LimpaErro) begin
            erro_d   = 1'b0;
            codigo_d = ERR_NONE;
        end
    end

    assign Sincronizado = (state_q == SINC);
    assign Volta        = volta_q;
    assign Periodos     = periodos_q;
    assign Erro         = erro_q;
    assign CodigoErro   = codigo_q;

endmodule
